// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array layer sequencer.
package sa_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WLOAD = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } sa_state_e;

    // Default array geometry and table shape
    localparam int SA_NUM_LAYERS_DEF = 4;
    localparam int SA_ROWS_DEF       = 25;
    localparam int SA_COLS_DEF       = 16;
    localparam int SA_BURST_W_DEF    = 11;

    // Power-on burst sizes (beats) for the first table entries
    localparam int SA_DEFAULT_BURST_N = 4;
    localparam int SA_DEFAULT_BURST [SA_DEFAULT_BURST_N] = '{784, 1176, 400, 0};

    // Default burst for any table index; entries past the known list start empty
    function automatic int sa_default_burst(input int idx);
        if (idx >= 0 && idx < SA_DEFAULT_BURST_N) begin
            return SA_DEFAULT_BURST[idx];
        end
        return 0;
    endfunction

endpackage

// File: rtl/sa_burst_table.sv
// Per-layer burst-size register file: one write port, one async read port,
// every entry returns to its package default on reset.
module sa_burst_table
    import sa_pkg::*;
#(
    parameter int  NUM_LAYERS = SA_NUM_LAYERS_DEF,
    parameter int  BURST_W    = SA_BURST_W_DEF,
    localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [LW-1:0]      wr_idx_i,
    input  logic [BURST_W-1:0] wr_data_i,
    input  logic [LW-1:0]      rd_idx_i,
    output logic [BURST_W-1:0] rd_data_o
);

    localparam logic [LW:0] NUM_L = (LW + 1)'(NUM_LAYERS);

    logic [BURST_W-1:0] entry_rd [NUM_LAYERS];

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_entry
            logic [BURST_W-1:0] entry_q;
            logic [BURST_W-1:0] entry_d;

            // Next value of this entry: take the write data when addressed
            always_comb begin
                entry_d = entry_q;
                if (we_i && (wr_idx_i == LW'(gi))) begin
                    entry_d = wr_data_i;
                end
            end

            // Entry storage, reloaded with its default on reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= BURST_W'(sa_default_burst(gi));
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entry_rd[gi] = entry_q;
        end
    endgenerate

    // Async read; indices past the table read as an empty (zero) burst
    always_comb begin
        rd_data_o = '0;
        if ({1'b0, rd_idx_i} < NUM_L) begin
            rd_data_o = entry_rd[rd_idx_i];
        end
    end

endmodule

// File: rtl/sa_layer_sequencer.sv
// Layer sequencer: per start, preload ROWS weight rows, stream one burst of
// data beats with handshake, drain the array, then report done/error.
module sa_layer_sequencer
    import sa_pkg::*;
#(
    parameter int  NUM_LAYERS = SA_NUM_LAYERS_DEF,
    parameter int  ROWS       = SA_ROWS_DEF,
    parameter int  COLS       = SA_COLS_DEF,
    parameter int  BURST_W    = SA_BURST_W_DEF,
    localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [LW-1:0]      layer_i,
    input  logic               cfg_we_i,
    input  logic [LW-1:0]      cfg_layer_i,
    input  logic [BURST_W-1:0] cfg_burst_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               w_load_o,
    output logic [RW-1:0]      w_row_o,
    output logic [LW-1:0]      w_layer_o,
    output logic               d_enable_o,
    input  logic               d_valid_i,
    input  logic               d_last_i,
    output logic               weight_stop_o,
    output logic [BURST_W-1:0] beat_cnt_o
);

    // Drain lasts until the last partial sum has left the array
    localparam int DRAIN_LEN = ROWS + COLS - 1;
    localparam int DW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    localparam logic [LW:0]   NUM_L      = (LW + 1)'(NUM_LAYERS);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

    sa_state_e          state_q, state_d;
    logic [LW-1:0]      layer_q, layer_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [RW-1:0]      row_q, row_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               mismatch_q, mismatch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               w_load_q, w_load_d;
    logic               d_enable_q, d_enable_d;
    logic               wstop_q, wstop_d;

    logic [BURST_W-1:0] tbl_burst;
    logic               layer_ok;
    logic               beat_acc;
    logic               last_beat;

    sa_burst_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .BURST_W    (BURST_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (cfg_we_i),
        .wr_idx_i  (cfg_layer_i),
        .wr_data_i (cfg_burst_i),
        .rd_idx_i  (layer_i),
        .rd_data_o (tbl_burst)
    );

    assign layer_ok  = ({1'b0, layer_i} < NUM_L);
    assign beat_acc  = d_enable_q && d_valid_i;
    assign last_beat = (beat_q == (burst_q - BURST_W'(1)));

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        burst_d    = burst_q;
        row_d      = row_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        mismatch_d = mismatch_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if ((tbl_burst == '0) || !layer_ok) begin
                        // Unusable layer: flag it and stay idle
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_WLOAD;
                        layer_d = layer_i;
                        burst_d = tbl_burst;
                        row_d   = '0;
                        beat_d  = '0;
                    end
                end
            end
            ST_WLOAD: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_DATA;
                    row_d   = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            ST_DATA: begin
                if (beat_acc) begin
                    beat_d = beat_q + BURST_W'(1);
                    // Source's last marker must coincide with the table's last beat
                    if (d_last_i != last_beat) begin
                        mismatch_d = 1'b1;
                    end
                    if (d_last_i || last_beat) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d    = ST_FIN;
                    done_d     = 1'b1;
                    err_d      = mismatch_q;
                    mismatch_d = 1'b0;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        w_load_d   = (state_d == ST_WLOAD);
        d_enable_d = (state_d == ST_DATA);
        wstop_d    = (state_d == ST_DATA) || (state_d == ST_DRAIN);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            layer_q    <= '0;
            burst_q    <= '0;
            row_q      <= '0;
            beat_q     <= '0;
            drain_q    <= '0;
            mismatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            w_load_q   <= 1'b0;
            d_enable_q <= 1'b0;
            wstop_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            burst_q    <= burst_d;
            row_q      <= row_d;
            beat_q     <= beat_d;
            drain_q    <= drain_d;
            mismatch_q <= mismatch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            w_load_q   <= w_load_d;
            d_enable_q <= d_enable_d;
            wstop_q    <= wstop_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign w_load_o      = w_load_q;
    assign w_row_o       = row_q;
    assign w_layer_o     = layer_q;
    assign d_enable_o    = d_enable_q;
    assign weight_stop_o = wstop_q;
    assign beat_cnt_o    = beat_q;

endmodule

// File: tb/tb_sa_layer_sequencer.sv
// Self-checking bench for sa_layer_sequencer. A timeline model derived from
// the layer-run rules predicts every output cycle by cycle.
module tb_sa_layer_sequencer;

    localparam int NUM_LAYERS = 4;
    localparam int ROWS       = 25;
    localparam int COLS       = 16;
    localparam int BURST_W    = 11;
    localparam int LW         = 2;
    localparam int RW         = 5;
    localparam int DRAIN_LEN  = ROWS + COLS - 1;
    localparam int M_ALWAYS   = 0;
    localparam int M_TOGGLE   = 1;
    localparam int M_RANDOM   = 2;
    localparam int T_LIMIT    = 20000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_i = 1'b0;
    logic [LW-1:0]      layer_i = '0;
    logic               cfg_we_i = 1'b0;
    logic [LW-1:0]      cfg_layer_i = '0;
    logic [BURST_W-1:0] cfg_burst_i = '0;
    logic               busy_o, done_o, err_o, w_load_o;
    logic [RW-1:0]      w_row_o;
    logic [LW-1:0]      w_layer_o;
    logic               d_enable_o;
    logic               d_valid_i = 1'b0;
    logic               d_last_i = 1'b0;
    logic               weight_stop_o;
    logic [BURST_W-1:0] beat_cnt_o;

    sa_layer_sequencer #(
        .NUM_LAYERS (NUM_LAYERS),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .BURST_W    (BURST_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .layer_i       (layer_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_layer_i   (cfg_layer_i),
        .cfg_burst_i   (cfg_burst_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .w_load_o      (w_load_o),
        .w_row_o       (w_row_o),
        .w_layer_o     (w_layer_o),
        .d_enable_o    (d_enable_o),
        .d_valid_i     (d_valid_i),
        .d_last_i      (d_last_i),
        .weight_stop_o (weight_stop_o),
        .beat_cnt_o    (beat_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Host-side view of the burst table
    int model_tbl [NUM_LAYERS];

    // Results of the most recent run
    int r_bad, r_beats_exp, r_beats_obs, r_err_exp, r_err_obs;
    int r_tdone_exp, r_tdone_obs, r_done_cyc, r_wload_cyc, r_wload_n, r_drain_n, r_den_after;

    task automatic model_reset_tbl();
        model_tbl[0] = 784;
        model_tbl[1] = 1176;
        model_tbl[2] = 400;
        model_tbl[3] = 0;
    endtask

    task automatic cfg_write(input int L, input int b);
        @(negedge clk);
        cfg_we_i    = 1'b1;
        cfg_layer_i = L[LW-1:0];
        cfg_burst_i = b[BURST_W-1:0];
        @(negedge clk);
        cfg_we_i = 1'b0;
        model_tbl[L] = b;
    endtask

    // Drive one layer run and compare every cycle with the timeline model.
    // t counts clock edges after the edge that sampled start_i.
    task automatic drive_run(input int L, input int mode, input int last_at,
                             input int midw_beat, input int midw_val,
                             input bit chain_out, input bit pre_started);
        int t, burst, cnt, t_data_end, t_done, data_start;
        bit data_done, mm, midw_done, v, timed_out;
        bit e_wload, e_den, e_wstop, e_busy, e_done, e_err;
        burst = model_tbl[L];
        cnt = 0; data_done = 0; mm = 0; midw_done = 0; timed_out = 1;
        t_done = T_LIMIT * 2; t_data_end = 0; data_start = ROWS + 1;
        r_bad = 0; r_done_cyc = -1; r_wload_cyc = -1; r_wload_n = 0; r_drain_n = 0;
        r_tdone_obs = -1; r_err_obs = -1; r_beats_obs = -1; r_den_after = -1;
        if (!pre_started) begin
            @(negedge clk);
            start_i = 1'b1;
            layer_i = L[LW-1:0];
        end
        @(negedge clk);
        start_i = 1'b0; cfg_we_i = 1'b0; d_valid_i = 1'b0; d_last_i = 1'b0;
        for (t = 1; t <= T_LIMIT; t++) begin
            e_wload = (t <= ROWS);
            e_den   = (t >= data_start) && !data_done;
            e_wstop = e_den || (data_done && (t <= t_data_end + DRAIN_LEN));
            e_busy  = (t <= t_done);
            e_done  = (t == t_done);
            e_err   = e_done && mm;
            if (w_load_o) begin
                r_wload_n++;
                if (r_wload_cyc < 0) r_wload_cyc = cyc;
            end
            if (weight_stop_o && !d_enable_o) r_drain_n++;
            if (data_done && t == t_data_end + 1) r_den_after = int'(d_enable_o);
            if (done_o && r_tdone_obs < 0) begin
                r_tdone_obs = t; r_done_cyc = cyc;
                r_err_obs = int'(err_o); r_beats_obs = int'(beat_cnt_o);
            end
            if (w_load_o !== e_wload || d_enable_o !== e_den || weight_stop_o !== e_wstop ||
                busy_o !== e_busy || done_o !== e_done || err_o !== e_err ||
                beat_cnt_o !== BURST_W'(cnt) ||
                (e_wload && w_row_o !== RW'(t - 1)) ||
                (e_busy && w_layer_o !== L[LW-1:0])) begin
                if (r_bad == 0)
                    $display("  divergence t=%0d wl=%0b row=%0d den=%0b ws=%0b busy=%0b done=%0b err=%0b beats=%0d model_beats=%0d",
                             t, w_load_o, w_row_o, d_enable_o, weight_stop_o, busy_o, done_o, err_o, beat_cnt_o, cnt);
                r_bad++;
            end
            if (t > t_done) begin
                if (chain_out) begin
                    start_i = 1'b1;
                    layer_i = L[LW-1:0];
                end
                timed_out = 0;
                break;
            end
            // Stimulus for this cycle
            start_i = 1'b0; cfg_we_i = 1'b0;
            if (mode == M_ALWAYS)      v = 1'b1;
            else if (mode == M_TOGGLE) v = ((t - data_start) % 2 == 0);
            else                       v = 1'($urandom_range(0, 1));
            if (e_den) begin
                if (midw_beat >= 0 && !midw_done && cnt == midw_beat) begin
                    cfg_we_i = 1'b1; cfg_layer_i = L[LW-1:0];
                    cfg_burst_i = midw_val[BURST_W-1:0]; start_i = 1'b1;
                    model_tbl[L] = midw_val; midw_done = 1;
                end
                d_valid_i = v;
                d_last_i  = v ? (cnt == last_at) : ((mode == M_RANDOM) && ($urandom_range(0, 3) == 0));
                if (v) begin
                    if ((cnt == last_at) != (cnt == burst - 1)) mm = 1;
                    if (cnt == last_at || cnt == burst - 1) begin
                        data_done = 1; t_data_end = t; t_done = t + DRAIN_LEN + 1;
                    end
                    cnt++;
                end
            end else begin
                d_valid_i = (mode == M_TOGGLE) ? 1'b0 : v;
                d_last_i  = (mode == M_RANDOM) && ($urandom_range(0, 3) == 0);
            end
            if (chain_out && t == t_done) begin
                start_i = 1'b1;
                layer_i = L[LW-1:0];
            end
            @(negedge clk);
        end
        if (timed_out) r_bad++;
        if (!chain_out) begin d_valid_i = 1'b0; d_last_i = 1'b0; end
        r_beats_exp = cnt; r_err_exp = int'(mm); r_tdone_exp = t_done;
        $display("run layer=%0d burst=%0d beats=%0d/%0d err=%0d/%0d latency=%0d divergent_cycles=%0d",
                 L, burst, r_beats_obs, r_beats_exp, r_err_obs, r_err_exp, r_tdone_obs + 1, r_bad);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, err_o, w_load_o, w_row_o, w_layer_o, d_enable_o, weight_stop_o, beat_cnt_o} !== '0)
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b wl=%0b beats=%0d, want all 0",
                     busy_o, done_o, err_o, w_load_o, beat_cnt_o);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, err_o, w_load_o, d_enable_o, weight_stop_o} !== '0)
            $display("FAIL reset_idle: got busy=%0b wl=%0b den=%0b ws=%0b, want all 0",
                     busy_o, w_load_o, d_enable_o, weight_stop_o);
        else n_pass++;
        $display("reset: outputs idle");
    endtask

    task automatic test_bad_start();
        int exp_err;
        exp_err = (model_tbl[3] == 0) ? 1 : 0;
        @(negedge clk);
        start_i = 1'b1; layer_i = 2'd3;
        @(negedge clk);
        start_i = 1'b0;
        n_checks++;
        if (err_o !== 1'(exp_err) || busy_o !== 1'b0 || w_load_o !== 1'b0)
            $display("FAIL bad_start_pulse: got err=%0b busy=%0b wl=%0b, want err=%0d busy=0 wl=0",
                     err_o, busy_o, w_load_o, exp_err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0 || w_load_o !== 1'b0)
            $display("FAIL bad_start_after: got err=%0b busy=%0b wl=%0b, want 0 0 0", err_o, busy_o, w_load_o);
        else n_pass++;
        $display("bad start layer=3: err pulse=%0d", exp_err);
    endtask

    task automatic test_layer0_full();
        drive_run(0, M_ALWAYS, 783, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_bad !== 0) $display("FAIL layer0_timeline: got %0d divergent cycles, want 0", r_bad);
        else n_pass++;
        n_checks++;
        if (r_wload_n !== ROWS) $display("FAIL layer0_wload_len: got %0d, want %0d", r_wload_n, ROWS);
        else n_pass++;
        n_checks++;
        if (r_beats_obs !== 784 || r_err_obs !== 0)
            $display("FAIL layer0_result: got beats=%0d err=%0d, want beats=784 err=0", r_beats_obs, r_err_obs);
        else n_pass++;
        n_checks++;
        if (r_drain_n !== DRAIN_LEN) $display("FAIL layer0_drain_len: got %0d, want %0d", r_drain_n, DRAIN_LEN);
        else n_pass++;
        n_checks++;
        if (r_tdone_obs + 1 !== 851) $display("FAIL layer0_latency: got %0d, want 851", r_tdone_obs + 1);
        else n_pass++;
    endtask

    task automatic test_cfg_toggle();
        cfg_write(3, 9);
        drive_run(3, M_TOGGLE, 8, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_bad !== 0) $display("FAIL toggle_timeline: got %0d divergent cycles, want 0", r_bad);
        else n_pass++;
        n_checks++;
        if (r_beats_obs !== 9 || r_err_obs !== 0)
            $display("FAIL toggle_result: got beats=%0d err=%0d, want beats=9 err=0", r_beats_obs, r_err_obs);
        else n_pass++;
        n_checks++;
        if (r_den_after !== 0) $display("FAIL toggle_enable_drop: got d_enable=%0d after last beat, want 0", r_den_after);
        else n_pass++;
    endtask

    task automatic test_early_last();
        drive_run(2, M_ALWAYS, 199, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_bad !== 0) $display("FAIL early_last_timeline: got %0d divergent cycles, want 0", r_bad);
        else n_pass++;
        n_checks++;
        if (r_beats_obs !== 200 || r_err_obs !== 1)
            $display("FAIL early_last_result: got beats=%0d err=%0d, want beats=200 err=1", r_beats_obs, r_err_obs);
        else n_pass++;
    endtask

    task automatic test_midrun_write();
        drive_run(1, M_RANDOM, 1175, 50, 5, 1'b0, 1'b0);
        n_checks++;
        if (r_bad !== 0) $display("FAIL midrun_timeline: got %0d divergent cycles, want 0", r_bad);
        else n_pass++;
        n_checks++;
        if (r_beats_obs !== 1176 || r_err_obs !== 0)
            $display("FAIL midrun_result: got beats=%0d err=%0d, want beats=1176 err=0", r_beats_obs, r_err_obs);
        else n_pass++;
        drive_run(1, M_ALWAYS, 4, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_bad !== 0 || r_beats_obs !== 5 || r_err_obs !== 0)
            $display("FAIL midrun_next: got beats=%0d err=%0d bad=%0d, want beats=5 err=0 bad=0",
                     r_beats_obs, r_err_obs, r_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        // Layer 1 now holds 5 beats: t=1..25 load, 26..30 data, drain from 31
        @(negedge clk);
        start_i = 1'b1; layer_i = 2'd1;
        @(negedge clk);
        start_i = 1'b0; d_valid_i = 1'b1; d_last_i = 1'b0;
        repeat (39) @(negedge clk);
        n_checks++;
        if (weight_stop_o !== 1'b1 || d_enable_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL drain_state: got ws=%0b den=%0b busy=%0b, want 1 0 1", weight_stop_o, d_enable_o, busy_o);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, err_o, w_load_o, w_row_o, w_layer_o, d_enable_o, weight_stop_o, beat_cnt_o} !== '0)
            $display("FAIL async_reset_outputs: got busy=%0b ws=%0b beats=%0d, want all 0",
                     busy_o, weight_stop_o, beat_cnt_o);
        else n_pass++;
        d_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset_tbl();
        $display("async reset in drain: outputs cleared");
        drive_run(1, M_ALWAYS, 1175, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (r_bad !== 0 || r_beats_obs !== 1176 || r_err_obs !== 0)
            $display("FAIL post_reset_run: got beats=%0d err=%0d bad=%0d, want beats=1176 err=0 bad=0",
                     r_beats_obs, r_err_obs, r_bad);
        else n_pass++;
    endtask

    task automatic test_random();
        int L, b, sel, last_at;
        for (int i = 0; i < 6; i++) begin
            L = $urandom_range(0, NUM_LAYERS - 1);
            b = $urandom_range(1, 24);
            sel = $urandom_range(0, 2);
            if (sel == 0)      last_at = b - 1;
            else if (sel == 1) last_at = -1;
            else               last_at = $urandom_range(0, b + 1);
            cfg_write(L, b);
            drive_run(L, M_RANDOM, last_at, -1, 0, 1'b0, 1'b0);
            n_checks++;
            if (r_bad !== 0 || r_beats_obs !== r_beats_exp || r_err_obs !== r_err_exp)
                $display("FAIL random_run%0d: got beats=%0d err=%0d bad=%0d, want beats=%0d err=%0d bad=0",
                         i, r_beats_obs, r_err_obs, r_bad, r_beats_exp, r_err_exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int first_bad, first_done_cyc;
        cfg_write(1, 7);
        drive_run(1, M_ALWAYS, 6, -1, 0, 1'b1, 1'b0);
        first_bad = r_bad; first_done_cyc = r_done_cyc;
        drive_run(1, M_RANDOM, 6, -1, 0, 1'b0, 1'b1);
        n_checks++;
        if (first_bad !== 0 || r_bad !== 0)
            $display("FAIL b2b_timeline: got %0d/%0d divergent cycles, want 0/0", first_bad, r_bad);
        else n_pass++;
        n_checks++;
        if (r_wload_cyc - first_done_cyc !== 2)
            $display("FAIL b2b_gap: got done->w_load %0d cycles, want 2", r_wload_cyc - first_done_cyc);
        else n_pass++;
    endtask

    initial begin
        model_reset_tbl();
        test_reset();
        test_bad_start();
        test_layer0_full();
        test_cfg_toggle();
        test_early_last();
        test_midrun_write();
        test_reset_mid_drain();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
